match_scheduler: RTL and testbench

// - Best-of-N match controller in front of fightingGame. Collects one action per player per turn via valid/ready, fires a one-cycle actionEnable, then samples firstWin/secondWin.
// - Scores rounds, re-resets fightingGame between rounds, and flags match end and the winner.

---
 rtl/fight_pkg.sv | 37 +++
 rtl/match_scheduler_turn_collector.sv | 55 +++++
 rtl/match_scheduler.sv | 148 ++++++++++++++
 tb/tb_match_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared definitions for the fightingGame match controller: action codes,
// controller states, winner codes and saturating counter helpers.
package fight_pkg;

  localparam logic [2:0] ACT_IDLE    = 3'b000;
  localparam logic [2:0] ACT_PUNCH   = 3'b001;
  localparam logic [2:0] ACT_KICK    = 3'b010;
  localparam logic [2:0] ACT_BLOCK   = 3'b011;
  localparam logic [2:0] ACT_JUMP    = 3'b100;
  localparam logic [2:0] ACT_CROUCH  = 3'b101;
  localparam logic [2:0] ACT_SPECIAL = 3'b110;
  localparam logic [2:0] ACT_THROW   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUND_RST,
    ST_COLLECT,
    ST_ISSUE,
    ST_SETTLE,
    ST_ROUND_END,
    ST_MATCH_DONE
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == '1) ? v : v + 3'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == '1) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/match_scheduler_turn_collector.sv
// One player's action slot for a turn: ready while open, latches the first
// offered action, or the idle action when the turn times out.
module turn_collector
  import fight_pkg::*;
#(
  parameter logic [2:0] IDLE_ACTION = ACT_IDLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       collect,
  input  logic       reopen,
  input  logic       timeout,
  input  logic       valid,
  input  logic [2:0] action,
  output logic       ready,
  output logic       done,
  output logic       timed_out,
  output logic [2:0] code
);

  logic       have;
  logic [2:0] slot;
  logic       take;
  logic       dflt;

  // Slot handshake; code/done include this cycle's capture so the FSM can
  // leave COLLECT on the same edge the last action is latched.
  always_comb begin
    ready = collect && !have;
    take  = ready && valid;
    dflt  = ready && !valid && timeout;
    done  = have || take || dflt;
    code  = take ? action : (dflt ? IDLE_ACTION : slot);
  end

  // Slot latch and sticky timeout flag, cleared when a new turn opens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have      <= 1'b0;
      slot      <= IDLE_ACTION;
      timed_out <= 1'b0;
    end else if (reopen) begin
      have      <= 1'b0;
      timed_out <= 1'b0;
    end else if (take) begin
      have <= 1'b1;
      slot <= action;
    end else if (dflt) begin
      have      <= 1'b1;
      slot      <= IDLE_ACTION;
      timed_out <= 1'b1;
    end
  end

endmodule

// File: rtl/match_scheduler.sv
// Best-of-N match controller in front of fightingGame: collects one action
// per player per turn, issues them, scores rounds and reports the winner.
module match_scheduler
  import fight_pkg::*;
#(
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter int unsigned MAX_ROUNDS    = 7,
  parameter int unsigned TURN_TIMEOUT  = 15,
  parameter logic [2:0]  IDLE_ACTION   = ACT_IDLE,
  parameter int unsigned RESET_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       resetGame,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [2:0] p1_action,
  output logic       p1_ready,
  input  logic       p2_valid,
  input  logic [2:0] p2_action,
  output logic       p2_ready,
  input  logic       firstWin,
  input  logic       secondWin,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       gameReset,
  output logic [3:0] round_num,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic [1:0] timed_out,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int unsigned   TW         = $clog2(TURN_TIMEOUT + 1);
  localparam int unsigned   RW         = $clog2(RESET_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [2:0]    WIN_SCORE  = 3'(ROUNDS_TO_WIN);
  localparam logic [3:0]    ROUND_CAP  = 4'(MAX_ROUNDS);

  state_t        state;
  state_t        next;
  logic [TW-1:0] timer;
  logic [RW-1:0] rst_cnt;
  logic          collect;
  logic          reopen;
  logic          timeout;
  logic          done1;
  logic          done2;
  logic [2:0]    code1;
  logic [2:0]    code2;

  turn_collector #(.IDLE_ACTION(IDLE_ACTION)) u_p1 (
    .clk       (clk),
    .rst       (resetGame),
    .collect   (collect),
    .reopen    (reopen),
    .timeout   (timeout),
    .valid     (p1_valid),
    .action    (p1_action),
    .ready     (p1_ready),
    .done      (done1),
    .timed_out (timed_out[0]),
    .code      (code1)
  );

  turn_collector #(.IDLE_ACTION(IDLE_ACTION)) u_p2 (
    .clk       (clk),
    .rst       (resetGame),
    .collect   (collect),
    .reopen    (reopen),
    .timeout   (timeout),
    .valid     (p2_valid),
    .action    (p2_action),
    .ready     (p2_ready),
    .done      (done2),
    .timed_out (timed_out[1]),
    .code      (code2)
  );

  // Next-state logic and state-decoded outputs.
  always_comb begin
    next         = state;
    collect      = (state == ST_COLLECT);
    timeout      = collect && (timer == TIMER_LAST);
    actionEnable = (state == ST_ISSUE);
    gameReset    = (state == ST_ROUND_RST);
    match_over   = (state == ST_MATCH_DONE);
    winner       = WIN_NONE;
    case (state)
      ST_IDLE:       if (start) next = ST_ROUND_RST;
      ST_ROUND_RST:  if (rst_cnt == RST_LAST) next = ST_COLLECT;
      ST_COLLECT:    if (done1 && done2) next = ST_ISSUE;
      ST_ISSUE:      next = ST_SETTLE;
      ST_SETTLE:     next = (firstWin || secondWin) ? ST_ROUND_END : ST_COLLECT;
      ST_ROUND_END:  next = (score1 == WIN_SCORE || score2 == WIN_SCORE ||
                             round_num == ROUND_CAP) ? ST_MATCH_DONE : ST_ROUND_RST;
      ST_MATCH_DONE: if (start) next = ST_ROUND_RST;
      default:       next = ST_IDLE;
    endcase
    if (state == ST_MATCH_DONE) begin
      if (score1 == WIN_SCORE)      winner = WIN_P1;
      else if (score2 == WIN_SCORE) winner = WIN_P2;
      else if (score1 > score2)     winner = WIN_P1;
      else if (score2 > score1)     winner = WIN_P2;
      else                          winner = WIN_TIE;
    end
    reopen = (next == ST_COLLECT) && (state != ST_COLLECT);
  end

  // State register, turn/reset timers, scoring and issued action registers.
  // Scores update on the SETTLE->ROUND_END edge so ROUND_END decides on them.
  always_ff @(posedge clk or posedge resetGame) begin
    if (resetGame) begin
      state     <= ST_IDLE;
      timer     <= '0;
      rst_cnt   <= '0;
      round_num <= '0;
      score1    <= '0;
      score2    <= '0;
      action1   <= IDLE_ACTION;
      action2   <= IDLE_ACTION;
    end else begin
      state   <= next;
      timer   <= (collect && next == ST_COLLECT) ? timer + TW'(1) : '0;
      rst_cnt <= (state == ST_ROUND_RST && next == ST_ROUND_RST) ? rst_cnt + RW'(1) : '0;
      if (next == ST_ROUND_RST && state != ST_ROUND_RST) begin
        if (state == ST_IDLE || state == ST_MATCH_DONE) begin
          score1    <= '0;
          score2    <= '0;
          round_num <= 4'd1;
        end else begin
          round_num <= sat_inc4(round_num);
        end
      end
      if (state == ST_SETTLE && next == ST_ROUND_END) begin
        if (firstWin && !secondWin)      score1 <= sat_inc3(score1);
        else if (secondWin && !firstWin) score2 <= sat_inc3(score2);
      end
      if (collect && next == ST_ISSUE) begin
        action1 <= code1;
        action2 <= code2;
      end
    end
  end

endmodule

// File: tb/tb_match_scheduler.sv
// Self-checking bench for match_scheduler: a turn/round-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_match_scheduler;

  localparam int RTW  = 2;
  localparam int MAXR = 7;
  localparam int TT   = 15;
  localparam int RC   = 2;

  logic       clk = 1'b0;
  logic       resetGame = 1'b1;
  logic       start = 1'b0;
  logic       p1_valid = 1'b0;
  logic [2:0] p1_action = 3'b000;
  logic       p1_ready;
  logic       p2_valid = 1'b0;
  logic [2:0] p2_action = 3'b000;
  logic       p2_ready;
  logic       firstWin = 1'b0;
  logic       secondWin = 1'b0;
  logic [2:0] action1;
  logic [2:0] action2;
  logic       actionEnable;
  logic       gameReset;
  logic [3:0] round_num;
  logic [2:0] score1;
  logic [2:0] score2;
  logic [1:0] timed_out;
  logic       match_over;
  logic [1:0] winner;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  match_scheduler #(
    .ROUNDS_TO_WIN(RTW),
    .MAX_ROUNDS   (MAXR),
    .TURN_TIMEOUT (TT),
    .IDLE_ACTION  (3'b000),
    .RESET_CYCLES (RC)
  ) dut (
    .clk         (clk),
    .resetGame   (resetGame),
    .start       (start),
    .p1_valid    (p1_valid),
    .p1_action   (p1_action),
    .p1_ready    (p1_ready),
    .p2_valid    (p2_valid),
    .p2_action   (p2_action),
    .p2_ready    (p2_ready),
    .firstWin    (firstWin),
    .secondWin   (secondWin),
    .action1     (action1),
    .action2     (action2),
    .actionEnable(actionEnable),
    .gameReset   (gameReset),
    .round_num   (round_num),
    .score1      (score1),
    .score2      (score2),
    .timed_out   (timed_out),
    .match_over  (match_over),
    .winner      (winner)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases of a match: waiting, resetting the game, gathering a turn,
  // firing it, reading the result, scoring, finished.
  localparam int PH_WAIT = 0, PH_GRST = 1, PH_GATHER = 2, PH_FIRE = 3,
                 PH_READ = 4, PH_SCORE = 5, PH_FINAL = 6;

  int         m_ph = PH_WAIT;
  int         m_cnt = 0;
  int         m_round = 0;
  int         m_s1 = 0;
  int         m_s2 = 0;
  bit         m_got1 = 0, m_got2 = 0;
  bit         m_to1 = 0, m_to2 = 0;
  logic [2:0] m_pick1 = 3'b000, m_pick2 = 3'b000;
  logic [2:0] m_shown1 = 3'b000, m_shown2 = 3'b000;
  bit         m_live = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [1:0] model_winner();
    if (m_ph != PH_FINAL) return 2'b00;
    if (m_s1 == RTW) return 2'b01;
    if (m_s2 == RTW) return 2'b10;
    if (m_s1 > m_s2) return 2'b01;
    if (m_s2 > m_s1) return 2'b10;
    return 2'b11;
  endfunction

  task automatic new_match();
    m_s1 = 0; m_s2 = 0; m_round = 1; m_ph = PH_GRST; m_cnt = 0;
  endtask

  task automatic open_turn();
    m_ph = PH_GATHER; m_cnt = 0; m_got1 = 0; m_got2 = 0; m_to1 = 0; m_to2 = 0;
  endtask

  always @(posedge clk or posedge resetGame) begin
    if (resetGame) begin
      m_ph = PH_WAIT; m_cnt = 0; m_round = 0; m_s1 = 0; m_s2 = 0;
      m_got1 = 0; m_got2 = 0; m_to1 = 0; m_to2 = 0;
      m_shown1 = 3'b000; m_shown2 = 3'b000;
      m_live = 1;
    end else begin
      case (m_ph)
        PH_WAIT, PH_FINAL: if (start) new_match();
        PH_GRST: begin
          if (m_cnt == RC - 1) open_turn();
          else m_cnt++;
        end
        PH_GATHER: begin
          if (!m_got1) begin
            if (p1_valid) begin m_pick1 = p1_action; m_got1 = 1; end
            else if (m_cnt == TT - 1) begin m_pick1 = 3'b000; m_got1 = 1; m_to1 = 1; end
          end
          if (!m_got2) begin
            if (p2_valid) begin m_pick2 = p2_action; m_got2 = 1; end
            else if (m_cnt == TT - 1) begin m_pick2 = 3'b000; m_got2 = 1; m_to2 = 1; end
          end
          if (m_got1 && m_got2) begin
            m_shown1 = m_pick1; m_shown2 = m_pick2; m_ph = PH_FIRE;
          end else m_cnt++;
        end
        PH_FIRE: m_ph = PH_READ;
        PH_READ: begin
          if (firstWin || secondWin) begin
            if (firstWin && !secondWin) m_s1 = imin(m_s1 + 1, 7);
            if (secondWin && !firstWin) m_s2 = imin(m_s2 + 1, 7);
            m_ph = PH_SCORE;
          end else open_turn();
        end
        PH_SCORE: begin
          if (m_s1 == RTW || m_s2 == RTW || m_round == MAXR) m_ph = PH_FINAL;
          else begin m_ph = PH_GRST; m_cnt = 0; m_round = imin(m_round + 1, 15); end
        end
        default: m_ph = PH_WAIT;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      check("p1_ready", {7'b0, p1_ready}, {7'b0, m_ph == PH_GATHER && !m_got1});
      check("p2_ready", {7'b0, p2_ready}, {7'b0, m_ph == PH_GATHER && !m_got2});
      check("actionEnable", {7'b0, actionEnable}, {7'b0, m_ph == PH_FIRE});
      check("gameReset", {7'b0, gameReset}, {7'b0, m_ph == PH_GRST});
      check("match_over", {7'b0, match_over}, {7'b0, m_ph == PH_FINAL});
      check("round_num", {4'b0, round_num}, 8'(m_round));
      check("score1", {5'b0, score1}, 8'(m_s1));
      check("score2", {5'b0, score2}, 8'(m_s2));
      check("timed_out", {6'b0, timed_out}, {6'b0, m_to2, m_to1});
      check("action1", {5'b0, action1}, {5'b0, m_shown1});
      check("action2", {5'b0, action2}, {5'b0, m_shown2});
      check("winner", {6'b0, winner}, {6'b0, model_winner()});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Plays turns with fixed actions until the match ends; counts gameReset cycles.
  task automatic run_match(input int budget, output int resets);
    int n = 0;
    resets = 0;
    while (!match_over && n < budget) begin
      if (gameReset) resets++;
      if (p1_ready && p2_ready) begin
        p1_valid = 1'b1; p1_action = 3'b010;
        p2_valid = 1'b1; p2_action = 3'b011;
      end
      step();
      p1_valid = 1'b0; p2_valid = 1'b0;
      n++;
    end
    check("lit_match_end_reached", {7'b0, match_over}, 8'd1);
  endtask

  initial begin
    int n;
    int resets;

    // Reset state
    repeat (3) step();
    check("lit_rst_round", {4'b0, round_num}, 8'd0);
    check("lit_rst_action1", {5'b0, action1}, 8'd0);
    check("lit_rst_ready", {6'b0, p2_ready, p1_ready}, 8'd0);
    check("lit_rst_over", {7'b0, match_over}, 8'd0);
    resetGame = 1'b0;
    step();
    check("lit_idle_ready", {6'b0, p2_ready, p1_ready}, 8'd0);

    // Start: two gameReset cycles, round 1
    start = 1'b1; step(); start = 1'b0;
    check("lit_grst0", {7'b0, gameReset}, 8'd1);
    check("lit_round1", {4'b0, round_num}, 8'd1);
    step();
    check("lit_grst1", {7'b0, gameReset}, 8'd1);
    step();
    check("lit_grst_done", {7'b0, gameReset}, 8'd0);
    check("lit_collect_ready", {6'b0, p2_ready, p1_ready}, 8'd3);

    // Both valid together: 110 / 100
    p1_valid = 1'b1; p1_action = 3'b110;
    p2_valid = 1'b1; p2_action = 3'b100;
    step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    check("lit_issue_en", {7'b0, actionEnable}, 8'd1);
    check("lit_issue_a1", {5'b0, action1}, 8'h06);
    check("lit_issue_a2", {5'b0, action2}, 8'h04);
    check("lit_issue_ready", {7'b0, p1_ready}, 8'd0);
    step();
    check("lit_settle_en", {7'b0, actionEnable}, 8'd0);
    check("lit_settle_a1", {5'b0, action1}, 8'h06);
    step();
    check("lit_ready_back", {6'b0, p2_ready, p1_ready}, 8'd3);

    // p2 silent, p1 holds valid and changes its code after capture; start ignored
    p1_valid = 1'b1; p1_action = 3'b001; start = 1'b1;
    step();
    start = 1'b0; p1_action = 3'b111;
    check("lit_dup_closed", {7'b0, p1_ready}, 8'd0);
    check("lit_start_ignored", {7'b0, gameReset}, 8'd0);
    n = 1;
    while (!actionEnable && n < 40) begin step(); n++; end
    check("lit_timeout_cycles", 8'(n), 8'd15);
    check("lit_to_a1", {5'b0, action1}, 8'h01);
    check("lit_to_a2", {5'b0, action2}, 8'h00);
    check("lit_to_flags", {6'b0, timed_out}, 8'h02);
    check("lit_to_round", {4'b0, round_num}, 8'd1);
    p1_valid = 1'b0;
    step();
    check("lit_to_sticky", {6'b0, timed_out}, 8'h02);
    step();
    check("lit_to_cleared", {6'b0, timed_out}, 8'h00);

    // Score path: player 1 wins two rounds
    firstWin = 1'b1; secondWin = 1'b0;
    run_match(200, resets);
    check("lit_win_resets", 8'(resets), 8'd2);
    check("lit_win_s1", {5'b0, score1}, 8'd2);
    check("lit_win_s2", {5'b0, score2}, 8'd0);
    check("lit_win_code", {6'b0, winner}, 8'h01);
    check("lit_win_round", {4'b0, round_num}, 8'd2);
    step();
    check("lit_done_hold", {5'b0, score1}, 8'd2);

    // Draw every round up to the round cap
    firstWin = 1'b1; secondWin = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    check("lit_restart_s1", {5'b0, score1}, 8'd0);
    run_match(600, resets);
    check("lit_draw_resets", 8'(resets), 8'd14);
    check("lit_draw_round", {4'b0, round_num}, 8'd7);
    check("lit_draw_winner", {6'b0, winner}, 8'h03);
    check("lit_draw_scores", {score2, score1}, 8'd0);

    // Reset mid-COLLECT after a scored round
    firstWin = 1'b1; secondWin = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!(p1_ready && p2_ready) && n < 20) begin step(); n++; end
    p1_valid = 1'b1; p2_valid = 1'b1; p1_action = 3'b101; p2_action = 3'b001;
    step();
    p1_valid = 1'b0; p2_valid = 1'b0;
    n = 0;
    while (!(p1_ready && p2_ready) && n < 20) begin step(); n++; end
    check("lit_mid_s1", {5'b0, score1}, 8'd1);
    check("lit_mid_round", {4'b0, round_num}, 8'd2);
    resetGame = 1'b1;
    #1;
    check("lit_abort_ready", {6'b0, p2_ready, p1_ready}, 8'd0);
    check("lit_abort_s1", {5'b0, score1}, 8'd0);
    check("lit_abort_round", {4'b0, round_num}, 8'd0);
    check("lit_abort_a1", {5'b0, action1}, 8'd0);
    step();
    resetGame = 1'b0;
    step();
    check("lit_abort_idle", {6'b0, p2_ready, p1_ready}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
